// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped LED/seven-segment/switch peripheral with poll handshakes and hex scan
module io_bus_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SEG_HOLD = 8,
  parameter int SCAN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [3:0]  hex
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(SEG_HOLD + 1);
  localparam int SCW = $clog2(SCAN_CYCLES + 1);
  logic btn_s1, btn_s2, db_lvl, db_prev, rise;
  logic [DW-1:0] db_cnt;
  logic [15:0] sw_s1, sw_s2, sw_data;
  logic [31:0] seg_data;
  logic out_rdy, seg_ovf, in_vld, in_ovr;
  logic [HW-1:0] hold;
  logic [SCW-1:0] scan;
  logic [2:0] digit;
  logic wr_led, wr_stat, wr_seg, ack;
  assign wr_led = io_we && io_addr == 8'h00;
  assign wr_stat = io_we && io_addr == 8'h08;
  assign wr_seg = io_we && io_addr == 8'h0C;
  assign ack = io_we && io_addr == 8'h10;
  assign rise = db_lvl & ~db_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      db_lvl <= 1'b0;
      db_prev <= 1'b0;
      db_cnt <= '0;
      led <= '0;
      seg_data <= '0;
      out_rdy <= 1'b1;
      seg_ovf <= 1'b0;
      hold <= '0;
      in_vld <= 1'b0;
      in_ovr <= 1'b0;
      sw_data <= '0;
      scan <= '0;
      digit <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      db_prev <= db_lvl;
      if (btn_s2 == db_lvl) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl <= btn_s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
      if (wr_led) led <= io_dout[15:0];
      if (wr_seg && out_rdy) begin
        seg_data <= io_dout;
        out_rdy <= 1'b0;
        hold <= HW'(SEG_HOLD);
      end else if (!out_rdy) begin
        out_rdy <= hold == HW'(1);
        hold <= hold - 1'b1;
      end
      if (wr_seg && !out_rdy) seg_ovf <= 1'b1;
      else if (wr_stat) seg_ovf <= 1'b0;
      // in_ovr can only be set while in_vld is high, so a fresh capture may clear it
      if (rise) begin
        if (!in_vld || ack) begin
          sw_data <= sw_s2;
          in_vld <= 1'b1;
          in_ovr <= 1'b0;
        end else in_ovr <= 1'b1;
      end else if (ack) begin
        in_vld <= 1'b0;
        in_ovr <= 1'b0;
      end
      if (scan == SCW'(SCAN_CYCLES - 1)) begin
        scan <= '0;
        digit <= digit + 1'b1;
      end else scan <= scan + 1'b1;
    end
  end
  assign an = 8'b1 << digit;
  assign hex = seg_data[{digit, 2'b00} +: 4];
  always_comb
    io_din = io_addr == 8'h00 ? {16'b0, led} :
             io_addr == 8'h08 ? {30'b0, seg_ovf, out_rdy} :
             io_addr == 8'h0C ? seg_data :
             io_addr == 8'h10 ? {30'b0, in_ovr, in_vld} :
             io_addr == 8'h14 ? {16'b0, sw_data} : 32'b0;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed and random stimulus checked against a behavioural peripheral model
module tb_io_bus_ctrl;
  localparam int D = 4, H = 8, S = 2;
  logic clk = 1'b0, rst = 1'b1, io_we = 1'b0, btn = 1'b0;
  logic [7:0] io_addr = '0, an;
  logic [31:0] io_dout = '0, io_din;
  logic [15:0] sw = '0, led;
  logic [3:0] hex;
  int nvec = 0, nerr = 0;
  io_bus_ctrl #(.DEBOUNCE_CYCLES(D), .SEG_HOLD(H), .SCAN_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_din(io_din), .sw(sw), .btn(btn), .led(led), .an(an), .hex(hex)
  );
  always #5 clk = ~clk;
  logic [15:0] m_led, m_swd, w1, w2;
  logic [31:0] m_seg;
  logic m_ovf, m_vld, m_ovr, b1, b2, m_lvl, m_prev, wv;
  logic sq[$];
  int since, t, wt;
  function automatic logic m_rdy();
    return !wv || (t - wt) >= H;
  endfunction
  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return {16'b0, m_led};
      8'h08: return {30'b0, m_ovf, m_rdy()};
      8'h0C: return m_seg;
      8'h10: return {30'b0, m_ovr, m_vld};
      8'h14: return {16'b0, m_swd};
      default: return 32'b0;
    endcase
  endfunction
  task automatic model_edge();
    logic rise, ack, ordy, diff;
    if (rst) begin
      m_led = '0; m_seg = '0; m_ovf = 0; m_vld = 0; m_ovr = 0; m_swd = '0;
      b1 = 0; b2 = 0; w1 = '0; w2 = '0; m_lvl = 0; m_prev = 0;
      sq.delete(); since = 0; t = 0; wv = 0; wt = 0;
    end else begin
      ordy = m_rdy();
      rise = m_lvl && !m_prev;
      ack = io_we && io_addr == 8'h10;
      sq.push_back(b2);
      if (sq.size() > D) sq.delete(0);
      since++;
      m_prev = m_lvl;
      diff = since >= D;
      foreach (sq[i]) if (sq[i] == m_lvl) diff = 0;
      if (diff) begin m_lvl = !m_lvl; since = 0; end
      if (rise) begin
        if (!m_vld || ack) begin m_swd = w2; m_vld = 1; m_ovr = 0; end
        else m_ovr = 1;
      end else if (ack) begin m_vld = 0; m_ovr = 0; end
      b2 = b1; b1 = btn; w2 = w1; w1 = sw;
      t++;
      if (io_we) case (io_addr)
        8'h00: m_led = io_dout[15:0];
        8'h08: m_ovf = 0;
        8'h0C: if (ordy) begin m_seg = io_dout; wv = 1; wt = t; end else m_ovf = 1;
        default: ;
      endcase
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] a, input logic w, input logic [31:0] d);
    int dg;
    rst = r; io_addr = a; io_we = w; io_dout = d;
    @(posedge clk);
    model_edge();
    #1;
    dg = (t / S) % 8;
    chk("led", {16'b0, led}, {16'b0, m_led});
    chk("an", {24'b0, an}, 32'd1 << dg);
    chk("hex", {28'b0, hex}, (m_seg >> (4 * dg)) & 32'hF);
    chk($sformatf("io_din@%h", a), io_din, m_read(a));
  endtask
  initial begin
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    chk("rst_status", io_din, 32'h0);
    step(0, 8'h00, 1, 32'hFFFF_A5A5);
    chk("led_a5a5", {16'b0, led}, 32'h0000_A5A5);
    chk("rd_led", io_din, 32'h0000_A5A5);
    step(0, 8'h04, 0, 0);
    chk("unmapped", io_din, 32'h0);
    sw = 16'h0003; btn = 1;
    for (int i = 0; i < 12; i++) step(0, 8'h10, 0, 0);
    step(0, 8'h14, 0, 0);
    chk("sw_cap", io_din, 32'h3);
    step(0, 8'h10, 1, 0);
    step(0, 8'h10, 0, 0);
    chk("ack_clr", io_din, 32'h0);
    btn = 0;
    for (int i = 0; i < 8; i++) step(0, 8'h10, 0, 0);
    for (int p = 0; p < 4; p++) begin
      btn = 1;
      for (int i = 0; i < D - 1; i++) step(0, 8'h10, 0, 0);
      btn = 0;
      for (int i = 0; i < 3; i++) step(0, 8'h10, 0, 0);
    end
    chk("glitch_none", io_din, 32'h0);
    btn = 1;
    for (int i = 0; i < 10; i++) step(0, 8'h10, 0, 0);
    btn = 0; sw = 16'h0005;
    for (int i = 0; i < 10; i++) step(0, 8'h10, 0, 0);
    btn = 1;
    for (int i = 0; i < 10; i++) step(0, 8'h10, 0, 0);
    chk("ovr_status", io_din, 32'h3);
    step(0, 8'h14, 0, 0);
    chk("sw_hold", io_din, 32'h3);
    btn = 0; sw = 16'h0009;
    for (int i = 0; i < 10; i++) step(0, 8'h10, 0, 0);
    btn = 1;
    for (int i = 0; i < 12; i++) step(0, 8'h10, m_lvl & ~m_prev, 0);
    chk("cap_ack_same", io_din, 32'h1);
    step(0, 8'h14, 0, 0);
    chk("cap_ack_sw", io_din, 32'h9);
    step(0, 8'h0C, 1, 32'h1234_5678);
    step(0, 8'h08, 0, 0);
    chk("seg_busy", io_din, 32'h0);
    step(0, 8'h0C, 1, 32'hDEAD_BEEF);
    chk("seg_keep", io_din, 32'h1234_5678);
    step(0, 8'h08, 0, 0);
    chk("seg_ovf", io_din, 32'h2);
    for (int i = 0; i < H; i++) step(0, 8'h08, 0, 0);
    chk("seg_rdy_ovf", io_din, 32'h3);
    step(0, 8'h08, 1, 0);
    chk("ovf_clr", io_din, 32'h1);
    for (int i = 0; i < 8 * S + 4; i++) step(0, 8'h0C, 0, 0);
    step(0, 8'h0C, 1, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) step(0, 8'h08, 0, 0);
    step(1, 8'h08, 0, 0);
    chk("rst_midhold", io_din, 32'h1);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      if ($urandom_range(5) == 0) btn = ~btn;
      if ($urandom_range(15) == 0) sw = 16'($urandom);
      case ($urandom_range(5))
        0: a = 8'h00; 1: a = 8'h04; 2: a = 8'h08;
        3: a = 8'h0C; 4: a = 8'h10; default: a = 8'h14;
      endcase
      step($urandom_range(149) == 0, a, $urandom_range(3) == 0, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
